// File: rtl/victim_cache_pkg.sv
// rtl/victim_cache_pkg.sv - shared types for the victim cache between L1 and L2
package victim_cache_pkg;

   localparam int V_TAG_W = 12;
   localparam int LINE_W  = 128;

   typedef logic [V_TAG_W-1:0] lc3b_v_tag;
   typedef logic [LINE_W-1:0]  lc3b_cache_line;

   typedef enum logic [2:0] {
      IDLE,
      HIT_RESP,
      L2_FETCH,
      WB,
      INSTALL
   } lc3b_vc_state;

   typedef struct packed {
      logic           valid;
      logic           dirty;
      lc3b_v_tag      tag;
      lc3b_cache_line data;
   } lc3b_vc_entry;

   function automatic logic [15:0] line_addr(input lc3b_v_tag tag);
      return {tag, 4'b0000};
   endfunction

endpackage

// File: rtl/victim_cache_array.sv
// rtl/victim_cache_array.sv - victim entry storage with parallel tag match and free-slot search
module victim_cache_array
   import victim_cache_pkg::*;
#(
   parameter int  ENTRIES = 4,
   localparam int IW      = $clog2(ENTRIES)
) (
   input  logic         clk,
   input  logic         rst,
   input  lc3b_v_tag    lookup_tag,
   input  logic         wr_en,
   input  logic [IW-1:0] wr_idx,
   input  lc3b_vc_entry wr_entry,
   input  logic         inv_en,
   input  logic [IW-1:0] inv_idx,
   input  logic [IW-1:0] vic_idx,
   output logic         hit,
   output logic [IW-1:0] hit_idx,
   output lc3b_vc_entry hit_entry,
   output logic         full,
   output logic [IW-1:0] free_idx,
   output lc3b_vc_entry vic_entry
);

   lc3b_vc_entry entries [ENTRIES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            entries[wr_idx] <= wr_entry;
         end
         if (inv_en) begin
            entries[inv_idx].valid <= 1'b0;
         end
      end
   end

   // Descending scan so the lowest matching / lowest free index wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      full     = 1'b1;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (entries[i].valid && (entries[i].tag == lookup_tag)) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
         if (!entries[i].valid) begin
            full     = 1'b0;
            free_idx = IW'(i);
         end
      end
   end

   assign hit_entry = entries[hit_idx];
   assign vic_entry = entries[vic_idx];

endmodule

// File: rtl/victim_cache.sv
// rtl/victim_cache.sv - fully-associative victim buffer: control FSM, FIFO pointer, output registers
module victim_cache
   import victim_cache_pkg::*;
#(
   parameter int ENTRIES = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          l1_read,
   input  logic          l1_write,
   input  logic [15:0]   l1_address,
   input  logic [127:0]  l1_wdata,
   input  logic          l1_dirty,
   output logic [127:0]  l1_rdata,
   output logic          l1_resp,
   output logic          l2_read,
   output logic          l2_write,
   output logic [15:0]   l2_address,
   output logic [127:0]  l2_wdata,
   input  logic [127:0]  l2_rdata,
   input  logic          l2_resp
);

   localparam int IW = $clog2(ENTRIES);

   lc3b_vc_state  state, state_n;
   logic [IW-1:0] ptr;
   lc3b_v_tag     tag;
   logic          offset_unused;

   logic          hit, full, wr_en, inv_en;
   logic [IW-1:0] hit_idx, free_idx, wr_idx;
   lc3b_vc_entry  hit_entry, vic_entry, wr_entry;

   assign tag           = l1_address[15:4];
   assign offset_unused = ^l1_address[3:0];

   victim_cache_array #(.ENTRIES(ENTRIES)) u_array (
      .clk        (clk),
      .rst        (rst),
      .lookup_tag (tag),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_entry   (wr_entry),
      .inv_en     (inv_en),
      .inv_idx    (hit_idx),
      .vic_idx    (ptr),
      .hit        (hit),
      .hit_idx    (hit_idx),
      .hit_entry  (hit_entry),
      .full       (full),
      .free_idx   (free_idx),
      .vic_entry  (vic_entry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      wr_en    = 1'b0;
      wr_idx   = ptr;
      inv_en   = 1'b0;
      wr_entry = '{valid: 1'b1, dirty: l1_dirty, tag: tag, data: l1_wdata};
      case (state)
         IDLE: begin
            if (l1_read) begin
               if (hit) begin
                  inv_en  = 1'b1;
                  state_n = HIT_RESP;
               end else begin
                  state_n = L2_FETCH;
               end
            end else if (l1_write) begin
               if (hit) begin
                  wr_en          = 1'b1;
                  wr_idx         = hit_idx;
                  wr_entry.dirty = hit_entry.dirty | l1_dirty;
                  state_n        = HIT_RESP;
               end else if (!full) begin
                  wr_en   = 1'b1;
                  wr_idx  = free_idx;
                  state_n = HIT_RESP;
               end else begin
                  state_n = vic_entry.dirty ? WB : INSTALL;
               end
            end
         end
         HIT_RESP: state_n = IDLE;
         L2_FETCH: if (l2_resp) state_n = HIT_RESP;
         WB:       if (l2_resp) state_n = INSTALL;
         INSTALL: begin
            wr_en   = 1'b1;
            state_n = IDLE;
         end
         default:  state_n = IDLE;
      endcase
   end

   // HIT_RESP doubles as the one-cycle response slot for hits, in-place writes and L2 fills.
   assign l1_resp  = (state == HIT_RESP) || (state == INSTALL);
   assign l2_read  = (state == L2_FETCH);
   assign l2_write = (state == WB);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= '0;
         l1_rdata   <= '0;
         l2_address <= '0;
         l2_wdata   <= '0;
      end else begin
         if (state == INSTALL) begin
            ptr <= ptr + 1'b1;
         end
         if (state == IDLE && l1_read && hit) begin
            l1_rdata <= hit_entry.data;
         end else if (state == L2_FETCH && l2_resp) begin
            l1_rdata <= l2_rdata;
         end
         if (state == IDLE && l1_read && !hit) begin
            l2_address <= line_addr(tag);
         end else if (state == IDLE && !l1_read && l1_write && !hit && full && vic_entry.dirty) begin
            l2_address <= line_addr(vic_entry.tag);
            l2_wdata   <= vic_entry.data;
         end
      end
   end

endmodule

// File: tb/tb_victim_cache.sv
// tb/tb_victim_cache.sv - scoreboard bench for victim_cache with a delayed-response L2 model
module tb_victim_cache;

   logic         clk = 1'b0;
   logic         rst;
   logic         l1_read, l1_write, l1_dirty;
   logic [15:0]  l1_address;
   logic [127:0] l1_wdata;
   logic [127:0] l1_rdata;
   logic         l1_resp;
   logic         l2_read, l2_write;
   logic [15:0]  l2_address;
   logic [127:0] l2_wdata;
   logic [127:0] l2_rdata;
   logic         l2_resp;

   typedef struct {
      bit           wr;
      logic [15:0]  addr;
      logic [127:0] data;
   } l2_item_t;

   l2_item_t     l2_q[$];
   logic [127:0] rd_q[$];
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   victim_cache #(.ENTRIES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .l1_read    (l1_read),
      .l1_write   (l1_write),
      .l1_address (l1_address),
      .l1_wdata   (l1_wdata),
      .l1_dirty   (l1_dirty),
      .l1_rdata   (l1_rdata),
      .l1_resp    (l1_resp),
      .l2_read    (l2_read),
      .l2_write   (l2_write),
      .l2_address (l2_address),
      .l2_wdata   (l2_wdata),
      .l2_rdata   (l2_rdata),
      .l2_resp    (l2_resp)
   );

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [127:0] mk_line(input logic [11:0] t);
      return {4{20'hBEEF0 ^ {8'h00, t}, t}};
   endfunction

   // L2 model: checks each request against the expected queue, answers two cycles later.
   initial begin
      l2_item_t it;
      l2_resp  = 1'b0;
      l2_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst && (l2_read || l2_write)) begin
            check("l2_exclusive", 128'(l2_read & l2_write), 128'(0));
            if (l2_q.size() == 0) begin
               check("l2_unexpected_req", 128'(l2_address), 128'hFFFF_FFFF);
               it = '{wr: l2_write, addr: l2_address, data: '0};
            end else begin
               it = l2_q.pop_front();
            end
            check("l2_is_write", 128'(l2_write), 128'(it.wr));
            check("l2_address", 128'(l2_address), 128'(it.addr));
            if (it.wr) check("l2_wdata", l2_wdata, it.data);
            repeat (2) @(negedge clk);
            l2_rdata = it.wr ? '0 : it.data;
            l2_resp  = 1'b1;
            @(negedge clk);
            l2_resp  = 1'b0;
         end
      end
   end

   task automatic l1_op(input bit wr, input logic [15:0] addr, input logic [127:0] wdata,
                        input bit dirty, input int exp_lat, input string name);
      int           cyc = 0;
      logic [127:0] exp;
      @(negedge clk);
      l1_read    = !wr;
      l1_write   = wr;
      l1_address = addr;
      l1_wdata   = wdata;
      l1_dirty   = dirty;
      do begin
         @(negedge clk);
         cyc++;
      end while (!l1_resp && cyc < 40);
      check({name, "_resp"}, 128'(l1_resp), 128'(1));
      check({name, "_latency"}, 128'(cyc), 128'(exp_lat));
      if (!wr && l1_resp) begin
         if (rd_q.size() == 0) begin
            check({name, "_rd_q_empty"}, 128'(0), 128'(1));
         end else begin
            exp = rd_q.pop_front();
            check({name, "_rdata"}, l1_rdata, exp);
         end
      end
      l1_read  = 1'b0;
      l1_write = 1'b0;
   endtask

   task automatic vc_write(input logic [15:0] addr, input logic [127:0] d, input bit dirty,
                           input string name);
      l1_op(1'b1, addr, d, dirty, 1, name);
   endtask

   task automatic vc_write_wb(input logic [15:0] addr, input logic [127:0] d, input bit dirty,
                              input logic [15:0] wb_addr, input logic [127:0] wb_data,
                              input string name);
      l2_q.push_back('{wr: 1'b1, addr: wb_addr, data: wb_data});
      l1_op(1'b1, addr, d, dirty, 4, name);
   endtask

   task automatic vc_read_hit(input logic [15:0] addr, input logic [127:0] d, input string name);
      rd_q.push_back(d);
      l1_op(1'b0, addr, '0, 1'b0, 1, name);
   endtask

   task automatic vc_read_miss(input logic [15:0] addr, input logic [127:0] d, input string name);
      l2_q.push_back('{wr: 1'b0, addr: {addr[15:4], 4'b0000}, data: d});
      rd_q.push_back(d);
      l1_op(1'b0, addr, '0, 1'b0, 4, name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst = 1'b1; l1_read = 1'b0; l1_write = 1'b0; l1_dirty = 1'b0;
      l1_address = '0; l1_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_l1_resp", 128'(l1_resp), 128'(0));
      check("rst_l2_read", 128'(l2_read), 128'(0));
      check("rst_l2_write", 128'(l2_write), 128'(0));
      check("rst_l1_rdata", l1_rdata, 128'(0));
      check("rst_l2_address", 128'(l2_address), 128'(0));
      check("rst_l2_wdata", l2_wdata, 128'(0));
      rst = 1'b0;

      // hit migrates the line back to L1, so a reread misses
      vc_write(16'h1230, mk_line(12'h123), 1'b0, "t1_ins");
      vc_read_hit(16'h1235, mk_line(12'h123), "t1_hit");
      vc_read_miss(16'h1230, mk_line(12'hF01), "t1_reread");

      // misses are not allocated
      vc_read_miss(16'h4560, mk_line(12'h456), "t2_miss");
      vc_read_miss(16'h4560, mk_line(12'hF02), "t2_remiss");

      vc_write(16'h0010, mk_line(12'h001), 1'b1, "t3_ins1");
      vc_write(16'h0020, mk_line(12'h002), 1'b0, "t3_ins2");
      vc_write(16'h0030, mk_line(12'h003), 1'b0, "t3_ins3");
      vc_write(16'h0040, mk_line(12'h004), 1'b0, "t3_ins4");
      vc_write_wb(16'h0050, mk_line(12'h005), 1'b0, 16'h0010, mk_line(12'h001), "t3_evict");
      vc_read_hit(16'h0050, mk_line(12'h005), "t3_hit5");

      // e0 free again; fill it, then four clean replacements wrap ptr back to e0
      vc_write(16'h0060, mk_line(12'h006), 1'b0, "t4_ins6");
      vc_write(16'h0070, mk_line(12'h007), 1'b0, "t4_rep7");
      vc_write(16'h0080, mk_line(12'h008), 1'b0, "t4_rep8");
      vc_write(16'h0090, mk_line(12'h009), 1'b0, "t4_rep9");
      vc_write(16'h00A0, mk_line(12'h00A), 1'b0, "t4_repA");
      vc_read_miss(16'h0060, mk_line(12'hF06), "t4_gone6");
      vc_read_miss(16'h0020, mk_line(12'hF07), "t4_gone2");
      vc_read_hit(16'h00A0, mk_line(12'h00A), "t4_hitA");

      vc_write(16'h0AB0, mk_line(12'h0AB), 1'b0, "t5_insAB");
      vc_write(16'h0AB0, ~mk_line(12'h0AB), 1'b1, "t5_ovrAB");
      vc_write(16'h00B0, mk_line(12'h00B), 1'b0, "t5_repB");
      vc_write(16'h00C0, mk_line(12'h00C), 1'b0, "t5_repC");
      vc_write(16'h00D0, mk_line(12'h00D), 1'b0, "t5_repD");
      vc_write_wb(16'h00E0, mk_line(12'h00E), 1'b0, 16'h0AB0, ~mk_line(12'h0AB), "t5_evictAB");
      vc_write(16'h00B0, ~mk_line(12'h00B), 1'b1, "t5_dirtyB");

      // reset while the dirty write-back of tag 0x0B is outstanding
      l2_q.push_back('{wr: 1'b1, addr: 16'h00B0, data: ~mk_line(12'h00B)});
      @(negedge clk);
      l1_write = 1'b1; l1_read = 1'b0; l1_address = 16'h00F0;
      l1_wdata = mk_line(12'h00F); l1_dirty = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!l2_write && cyc < 40);
      check("t6_l2_write_seen", 128'(l2_write), 128'(1));
      @(negedge clk);
      rst = 1'b1; l1_write = 1'b0;
      @(negedge clk);
      check("t6_l2_write_drop", 128'(l2_write), 128'(0));
      check("t6_l2_read_low", 128'(l2_read), 128'(0));
      check("t6_l1_resp_low", 128'(l1_resp), 128'(0));
      check("t6_l2_address_clr", 128'(l2_address), 128'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vc_read_miss(16'h00E0, mk_line(12'hF0E), "t6_lostE");
      vc_read_miss(16'h00C0, mk_line(12'hF0C), "t6_lostC");

      repeat (4) @(negedge clk);
      check("l2_q_drained", 128'(l2_q.size()), 128'(0));
      check("rd_q_drained", 128'(rd_q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
